activation_backward: RTL and testbench

ACTIVATION_BACKWARD -- requirements
Module: activation_backward

---
 rtl/activation_backward.sv | 138 +++++++++++++
 tb/tb_activation_backward.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/activation_backward.sv
// Element-serial activation backward pass: grad_in[i] = f'(pre_act[i]) * grad_out[i] for ReLU / Leaky ReLU.
// Optional zero-element counter is enabled with the ACT_BWD_ZERO_COUNT_EN macro.
module activation_backward #(
  parameter int DATA_WIDTH     = 8,
  parameter int NUM_ELEMENTS   = 16,
  parameter int USE_LEAKY_RELU = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  output logic                                 done,
  output logic                                 busy,
  input  logic [DATA_WIDTH*NUM_ELEMENTS-1:0]   pre_act_flat,
  input  logic [DATA_WIDTH*NUM_ELEMENTS-1:0]   grad_out_flat,
  output logic [DATA_WIDTH*NUM_ELEMENTS-1:0]   grad_in_flat
`ifdef ACT_BWD_ZERO_COUNT_EN
  ,
  output logic [$clog2(NUM_ELEMENTS+1)-1:0]    zero_count
`endif
);

  localparam int FLAT_W = DATA_WIDTH * NUM_ELEMENTS;
  localparam int IDX_W  = (NUM_ELEMENTS > 1) ? $clog2(NUM_ELEMENTS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEMENTS - 1);

  typedef enum logic [1:0] {
    IDLE,
    PROCESS,
    DONE
  } state_e;

  state_e                       state_q, state_d;
  logic [FLAT_W-1:0]            pre_act_q, pre_act_d;
  logic [FLAT_W-1:0]            grad_out_q, grad_out_d;
  logic [FLAT_W-1:0]            grad_in_q, grad_in_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic                         done_q, done_d;
  logic                         cur_neg;
  logic signed [DATA_WIDTH-1:0] cur_grad;
  logic signed [DATA_WIDTH-1:0] cur_result;

  // Derivative of the activation applied to the element currently addressed by idx_q.
  always_comb begin
    cur_neg  = pre_act_q[idx_q*DATA_WIDTH + DATA_WIDTH - 1];
    cur_grad = grad_out_q[idx_q*DATA_WIDTH +: DATA_WIDTH];
    if (!cur_neg) begin
      cur_result = cur_grad;
    end else if (USE_LEAKY_RELU != 0) begin
      cur_result = cur_grad >>> 7;
    end else begin
      cur_result = '0;
    end
  end

  always_comb begin
    state_d    = state_q;
    pre_act_d  = pre_act_q;
    grad_out_d = grad_out_q;
    grad_in_d  = grad_in_q;
    idx_d      = idx_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = PROCESS;
          pre_act_d  = pre_act_flat;
          grad_out_d = grad_out_flat;
          grad_in_d  = '0;
          idx_d      = '0;
        end
      end
      PROCESS: begin
        grad_in_d[idx_q*DATA_WIDTH +: DATA_WIDTH] = cur_result;
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          done_d  = 1'b1;
          idx_d   = '0;
        end
      end
      DONE: begin
        // Stay here until start drops so a held start cannot retrigger.
        if (!start) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      pre_act_q  <= '0;
      grad_out_q <= '0;
      grad_in_q  <= '0;
      idx_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pre_act_q  <= pre_act_d;
      grad_out_q <= grad_out_d;
      grad_in_q  <= grad_in_d;
      idx_q      <= idx_d;
      done_q     <= done_d;
    end
  end

  assign done         = done_q;
  assign busy         = (state_q == PROCESS);
  assign grad_in_flat = grad_in_q;

`ifdef ACT_BWD_ZERO_COUNT_EN
  localparam int CNT_W = $clog2(NUM_ELEMENTS + 1);

  logic [CNT_W-1:0] zero_count_q, zero_count_d;

  always_comb begin
    zero_count_d = zero_count_q;
    if (state_q == IDLE && start) begin
      zero_count_d = '0;
    end else if (state_q == PROCESS && cur_result == '0) begin
      zero_count_d = zero_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      zero_count_q <= '0;
    end else begin
      zero_count_q <= zero_count_d;
    end
  end

  assign zero_count = zero_count_q;
`endif

endmodule

// File: tb/tb_activation_backward.sv
// Self-checking bench for activation_backward: ReLU and Leaky ReLU instances run side by side
// against a behavioural per-run model, plus hand-computed literal expectations.
module tb_activation_backward;

  localparam int W  = 8;
  localparam int N  = 16;
  localparam int FW = W * N;
  localparam int CW = $clog2(N + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [FW-1:0] preActFlat = '0;
  logic [FW-1:0] gradOutFlat = '0;
  logic          doneLeaky, busyLeaky, doneRelu, busyRelu;
  logic [FW-1:0] gradInLeaky, gradInRelu;
`ifdef ACT_BWD_ZERO_COUNT_EN
  logic [CW-1:0] zeroLeaky, zeroRelu;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  activation_backward #(.DATA_WIDTH(W), .NUM_ELEMENTS(N), .USE_LEAKY_RELU(1)) dutLeaky (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .done         (doneLeaky),
    .busy         (busyLeaky),
    .pre_act_flat (preActFlat),
    .grad_out_flat(gradOutFlat),
    .grad_in_flat (gradInLeaky)
`ifdef ACT_BWD_ZERO_COUNT_EN
    ,
    .zero_count   (zeroLeaky)
`endif
  );

  activation_backward #(.DATA_WIDTH(W), .NUM_ELEMENTS(N), .USE_LEAKY_RELU(0)) dutRelu (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .done         (doneRelu),
    .busy         (busyRelu),
    .pre_act_flat (preActFlat),
    .grad_out_flat(gradOutFlat),
    .grad_in_flat (gradInRelu)
`ifdef ACT_BWD_ZERO_COUNT_EN
    ,
    .zero_count   (zeroRelu)
`endif
  );

  task automatic checkOutput(input string name, input logic [FW-1:0] actual, input logic [FW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  function automatic logic [FW-1:0] fill(input logic [W-1:0] b);
    logic [FW-1:0] v;
    for (int i = 0; i < N; i++) v[i*W +: W] = b;
    return v;
  endfunction

  // Negative pre-activation: leaky slope 1/128 means floor(grad/128), i.e. -1 or 0 for 8-bit grads.
  function automatic logic [W-1:0] derive(input logic [W-1:0] pre, input logic [W-1:0] grad, input bit leaky);
    if ($signed(pre) >= 0) return grad;
    if (!leaky) return '0;
    return ($signed(grad) < 0) ? '1 : '0;
  endfunction

  bit            modelValid = 0;
  bit            modelRunning = 0;
  bit            modelHolding = 0;
  int            modelStep = 0;
  bit            expBusy = 0;
  bit            expDone = 0;
  int            expZeroLeaky = 0;
  int            expZeroRelu = 0;
  logic [W-1:0]  capPre[N];
  logic [W-1:0]  capGrad[N];
  logic [W-1:0]  expLeaky[N];
  logic [W-1:0]  expRelu[N];

  // Behavioural model: one result element appears per edge after capture, done follows the last one.
  always @(posedge clk) begin
    expDone = 0;
    if (!rst) begin
      modelValid   = 1;
      modelRunning = 0;
      modelHolding = 0;
      modelStep    = 0;
      expZeroLeaky = 0;
      expZeroRelu  = 0;
      for (int i = 0; i < N; i++) begin
        expLeaky[i] = '0;
        expRelu[i]  = '0;
      end
    end else if (modelRunning) begin
      expLeaky[modelStep] = derive(capPre[modelStep], capGrad[modelStep], 1'b1);
      expRelu[modelStep]  = derive(capPre[modelStep], capGrad[modelStep], 1'b0);
      if (expLeaky[modelStep] == '0) expZeroLeaky++;
      if (expRelu[modelStep] == '0) expZeroRelu++;
      modelStep++;
      if (modelStep == N) begin
        modelRunning = 0;
        modelHolding = 1;
        expDone      = 1;
      end
    end else if (modelHolding) begin
      if (!start) modelHolding = 0;
    end else if (start) begin
      for (int i = 0; i < N; i++) begin
        capPre[i]   = preActFlat[i*W +: W];
        capGrad[i]  = gradOutFlat[i*W +: W];
        expLeaky[i] = '0;
        expRelu[i]  = '0;
      end
      expZeroLeaky = 0;
      expZeroRelu  = 0;
      modelStep    = 0;
      modelRunning = 1;
    end
    expBusy = modelRunning;
  end

  always @(negedge clk) begin
    logic [FW-1:0] packedLeaky;
    logic [FW-1:0] packedRelu;
    if (modelValid) begin
      for (int i = 0; i < N; i++) begin
        packedLeaky[i*W +: W] = expLeaky[i];
        packedRelu[i*W +: W]  = expRelu[i];
      end
      checkOutput("cycleBusyLeaky", FW'(busyLeaky), FW'(expBusy));
      checkOutput("cycleBusyRelu", FW'(busyRelu), FW'(expBusy));
      checkOutput("cycleDoneLeaky", FW'(doneLeaky), FW'(expDone));
      checkOutput("cycleDoneRelu", FW'(doneRelu), FW'(expDone));
      checkOutput("cycleGradLeaky", gradInLeaky, packedLeaky);
      checkOutput("cycleGradRelu", gradInRelu, packedRelu);
`ifdef ACT_BWD_ZERO_COUNT_EN
      checkOutput("cycleZeroLeaky", FW'(zeroLeaky), FW'(expZeroLeaky));
      checkOutput("cycleZeroRelu", FW'(zeroRelu), FW'(expZeroRelu));
`endif
    end
  end

  task automatic applyStimulus(input logic [FW-1:0] pre, input logic [FW-1:0] grad);
    @(negedge clk);
    preActFlat  = pre;
    gradOutFlat = grad;
  endtask

  // Raises start for the capture edge and counts edges (capture edge = 1) until done is seen.
  task automatic startRun(input bit holdStart, input bit doScramble, input logic [FW-1:0] scramble,
                          output int edges);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    if (!holdStart) start = 1'b0;
    if (doScramble) begin
      preActFlat  = scramble;
      gradOutFlat = scramble;
    end
    while (!doneLeaky && edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    checkOutput("doneLatency", FW'(edges), FW'(N + 1));
  endtask

  initial begin
    int edges;
    int doneCount;
    int busyCount;
    logic [FW-1:0] pre;
    logic [FW-1:0] grad;

    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("resetDone", FW'(doneLeaky), '0);
    checkOutput("resetBusy", FW'(busyRelu), '0);
    checkOutput("resetGradIn", gradInLeaky, '0);
`ifdef ACT_BWD_ZERO_COUNT_EN
    checkOutput("resetZeroCount", FW'(zeroRelu), '0);
`endif
    rst = 1'b1;

    $display("[TB] all-negative pre-activations");
    applyStimulus(fill(8'h80), fill(8'h10));
    startRun(1'b0, 1'b0, '0, edges);
    checkOutput("negReluGrad", gradInRelu, '0);
    checkOutput("negLeakyGrad", gradInLeaky, '0);
`ifdef ACT_BWD_ZERO_COUNT_EN
    checkOutput("negReluZeroCount", FW'(zeroRelu), FW'(16));
`endif

    $display("[TB] mixed elements with inputs scrambled after capture");
    for (int i = 0; i < N; i++) begin
      pre[i*W +: W]  = (i % 2 == 1) ? 8'hC0 : 8'(8'h20 + i);
      grad[i*W +: W] = 8'(8'h90 + i * 5);
    end
    pre[7:0]    = 8'hFF; grad[7:0]   = 8'h80;
    pre[15:8]   = 8'hFF; grad[15:8]  = 8'h40;
    pre[23:16]  = 8'h00; grad[23:16] = 8'h7F;
    applyStimulus(pre, grad);
    startRun(1'b0, 1'b1, fill(8'h55), edges);
    checkOutput("leakyElem0", FW'(gradInLeaky[7:0]), FW'(8'hFF));
    checkOutput("leakyElem1", FW'(gradInLeaky[15:8]), FW'(8'h00));
    checkOutput("leakyElem2", FW'(gradInLeaky[23:16]), FW'(8'h7F));
    checkOutput("reluElem0", FW'(gradInRelu[7:0]), FW'(8'h00));
    checkOutput("reluElem2", FW'(gradInRelu[23:16]), FW'(8'h7F));

    $display("[TB] start held through completion");
    for (int i = 0; i < N; i++) begin
      pre[i*W +: W]  = (i < 8) ? 8'hF0 : 8'h01;
      grad[i*W +: W] = (i % 3 == 0) ? 8'hE0 : 8'h21;
    end
    applyStimulus(pre, grad);
    startRun(1'b1, 1'b0, '0, edges);
    doneCount = 0;
    busyCount = 0;
    repeat (10) begin
      @(negedge clk);
      if (doneLeaky) doneCount++;
      if (busyLeaky) busyCount++;
    end
    checkOutput("heldStartExtraDone", FW'(doneCount), '0);
    checkOutput("heldStartBusy", FW'(busyCount), '0);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    checkOutput("restartBusy", FW'(busyLeaky), FW'(1));
    start = 1'b0;
    edges = 0;
    while (!doneLeaky && edges < 40) begin
      @(negedge clk);
      edges++;
    end
    checkOutput("restartCompletes", FW'(doneLeaky), FW'(1));

    $display("[TB] reset in the middle of a run");
    applyStimulus(fill(8'h81), fill(8'h92));
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abortGradIn", gradInLeaky, '0);
    checkOutput("abortBusy", FW'(busyLeaky), '0);
    checkOutput("abortDone", FW'(doneRelu), '0);
    rst = 1'b1;
    doneCount = 0;
    repeat (20) begin
      @(negedge clk);
      if (doneLeaky || doneRelu) doneCount++;
    end
    checkOutput("abortNoDone", FW'(doneCount), '0);
    for (int i = 0; i < N; i++) grad[i*W +: W] = 8'(i * 3);
    applyStimulus(fill(8'h01), grad);
    startRun(1'b0, 1'b0, '0, edges);
    checkOutput("postAbortRelu", gradInRelu, grad);
    checkOutput("postAbortLeaky", gradInLeaky, grad);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
